// File: rtl/iir_sos_pkg.sv
// Shared types, coefficient slot numbering and width helpers for the biquad cascade.
package iir_sos_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StMac,
    StWb,
    StDone
  } state_e;

  localparam logic [2:0] COEF_B0 = 3'd0;
  localparam logic [2:0] COEF_B1 = 3'd1;
  localparam logic [2:0] COEF_B2 = 3'd2;
  localparam logic [2:0] COEF_A1 = 3'd3;
  localparam logic [2:0] COEF_A2 = 3'd4;
  localparam int unsigned NUM_TERMS = 5;

  // Widest value the saturation helper can inspect.
  localparam int unsigned SatMaxW = 128;

  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Returns {over, under} for a signed value against a w-bit signed range.
  function automatic logic [1:0] saturate(input logic signed [SatMaxW-1:0] v,
                                          input int unsigned w);
    logic signed [SatMaxW-1:0] lim;
    lim = SatMaxW'(1) <<< (w - 1);
    return {v > (lim - SatMaxW'(1)), v < -lim};
  endfunction

endpackage

// File: rtl/iir_sos_mac.sv
// Shared multiply-accumulate with round, arithmetic shift and output saturation.
module iir_sos_mac
  import iir_sos_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned COEFF_WIDTH    = 32,
  parameter int unsigned INTERNAL_WIDTH = 64,
  parameter int unsigned SCALE_SHIFT    = 20
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          clear,
  input  logic                          en,
  input  logic                          first,
  input  logic                          sub,
  input  logic signed [DATA_WIDTH-1:0]  data,
  input  logic signed [COEFF_WIDTH-1:0] coef,
  output logic signed [DATA_WIDTH-1:0]  y,
  output logic                          sat
);

  localparam logic signed [INTERNAL_WIDTH-1:0] RoundBias =
      (SCALE_SHIFT == 0) ? '0 : (INTERNAL_WIDTH'(1) <<< (SCALE_SHIFT - 1));

  logic signed [INTERNAL_WIDTH-1:0] acc_q, acc_d, data_ext, coef_ext, prod, base, rnd;
  logic signed [SatMaxW-1:0]        wide;
  logic [1:0]                       dir;

  always_comb begin
    data_ext = INTERNAL_WIDTH'(data);
    coef_ext = INTERNAL_WIDTH'(coef);
    prod     = data_ext * coef_ext;
    // The first term of a section overwrites whatever the previous section left behind.
    base     = first ? '0 : acc_q;
    acc_d    = sub ? (base - prod) : (base + prod);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else if (clear) begin
      acc_q <= '0;
    end else if (en) begin
      acc_q <= acc_d;
    end
  end

  always_comb begin
    rnd  = (acc_q + RoundBias) >>> SCALE_SHIFT;
    wide = SatMaxW'(rnd);
    dir  = saturate(wide, DATA_WIDTH);
    sat  = |dir;
    if (dir[1]) begin
      y = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    end else if (dir[0]) begin
      y = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    end else begin
      y = rnd[DATA_WIDTH-1:0];
    end
  end

endmodule

// File: rtl/iir_sos_cascade.sv
// Cascade of Direct-Form-I biquads sharing one MAC, with sample handshake and coefficient port.
module iir_sos_cascade
  import iir_sos_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned COEFF_WIDTH    = 32,
  parameter int unsigned INTERNAL_WIDTH = 64,
  parameter int unsigned SCALE_SHIFT    = 20,
  parameter int unsigned NUM_SECTIONS   = 4,
  localparam int unsigned SEC_W = clog2_min1(NUM_SECTIONS)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          clear,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic signed [DATA_WIDTH-1:0]  in_data,
  output logic                          out_valid,
  output logic signed [DATA_WIDTH-1:0]  out_data,
  output logic                          out_sat,
  input  logic                          coef_we,
  output logic                          coef_ready,
  input  logic [SEC_W-1:0]              coef_sec,
  input  logic [2:0]                    coef_idx,
  input  logic signed [COEFF_WIDTH-1:0] coef_wdata
);

  localparam logic signed [COEFF_WIDTH-1:0] UnityCoef = COEFF_WIDTH'(1) << SCALE_SHIFT;

  state_e                        state_q, state_d;
  logic [SEC_W-1:0]              sec_q;
  logic [2:0]                    term_q;
  logic signed [DATA_WIDTH-1:0]  x_q;
  logic                          sat_acc_q;
  logic signed [COEFF_WIDTH-1:0] coef_q [NUM_SECTIONS][NUM_TERMS];
  logic signed [DATA_WIDTH-1:0]  x1_q [NUM_SECTIONS];
  logic signed [DATA_WIDTH-1:0]  x2_q [NUM_SECTIONS];
  logic signed [DATA_WIDTH-1:0]  y1_q [NUM_SECTIONS];
  logic signed [DATA_WIDTH-1:0]  y2_q [NUM_SECTIONS];

  logic                          accept, mac_en, mac_first, mac_sub, mac_sat;
  logic                          wb, done, last_sec, coef_ok;
  logic signed [DATA_WIDTH-1:0]  mac_data, mac_y;
  logic signed [COEFF_WIDTH-1:0] mac_coef;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    in_ready   = (state_q == StIdle) && !clear;
    coef_ready = (state_q == StIdle);
    accept     = in_valid && in_ready;
    mac_en     = 1'b0;
    mac_first  = 1'b0;
    wb         = 1'b0;
    done       = 1'b0;
    unique case (state_q)
      StIdle: if (accept) state_d = StMac;
      StMac: begin
        mac_en    = 1'b1;
        mac_first = (term_q == COEF_B0);
        if (term_q == COEF_A2) state_d = StWb;
      end
      StWb: begin
        wb      = 1'b1;
        state_d = last_sec ? StDone : StMac;
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (clear) begin
      state_d = StIdle;
      mac_en  = 1'b0;
      wb      = 1'b0;
      done    = 1'b0;
    end
  end

  always_comb begin
    last_sec = (32'(sec_q) == NUM_SECTIONS - 1);
    coef_ok  = coef_we && coef_ready && (32'(coef_sec) < NUM_SECTIONS) && (coef_idx <= COEF_A2);
    mac_coef = coef_q[sec_q][term_q];
    mac_sub  = (term_q >= COEF_A1);
    case (term_q)
      COEF_B1: mac_data = x1_q[sec_q];
      COEF_B2: mac_data = x2_q[sec_q];
      COEF_A1: mac_data = y1_q[sec_q];
      COEF_A2: mac_data = y2_q[sec_q];
      default: mac_data = x_q;
    endcase
  end

  iir_sos_mac #(
    .DATA_WIDTH     (DATA_WIDTH),
    .COEFF_WIDTH    (COEFF_WIDTH),
    .INTERNAL_WIDTH (INTERNAL_WIDTH),
    .SCALE_SHIFT    (SCALE_SHIFT)
  ) u_mac (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .en    (mac_en),
    .first (mac_first),
    .sub   (mac_sub),
    .data  (mac_data),
    .coef  (mac_coef),
    .y     (mac_y),
    .sat   (mac_sat)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sec_q     <= '0;
      term_q    <= '0;
      x_q       <= '0;
      sat_acc_q <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= 1'b0;
      for (int unsigned s = 0; s < NUM_SECTIONS; s++) begin
        x1_q[s] <= '0;
        x2_q[s] <= '0;
        y1_q[s] <= '0;
        y2_q[s] <= '0;
        for (int unsigned t = 0; t < NUM_TERMS; t++) begin
          coef_q[s][t] <= (t == 0) ? UnityCoef : '0;
        end
      end
    end else begin
      out_valid <= done;
      if (coef_ok) coef_q[coef_sec][coef_idx] <= coef_wdata;
      if (clear) begin
        term_q    <= '0;
        sat_acc_q <= 1'b0;
        for (int unsigned s = 0; s < NUM_SECTIONS; s++) begin
          x1_q[s] <= '0;
          x2_q[s] <= '0;
          y1_q[s] <= '0;
          y2_q[s] <= '0;
        end
      end else begin
        if (accept) begin
          x_q       <= in_data;
          sec_q     <= '0;
          term_q    <= '0;
          sat_acc_q <= 1'b0;
        end
        if (mac_en) term_q <= (term_q == COEF_A2) ? 3'd0 : term_q + 3'd1;
        if (wb) begin
          // x_q carries the section input now and the next section's input afterwards.
          x2_q[sec_q] <= x1_q[sec_q];
          x1_q[sec_q] <= x_q;
          y2_q[sec_q] <= y1_q[sec_q];
          y1_q[sec_q] <= mac_y;
          x_q         <= mac_y;
          sat_acc_q   <= sat_acc_q | mac_sat;
          if (!last_sec) sec_q <= sec_q + SEC_W'(1);
        end
        if (done) begin
          out_data <= x_q;
          out_sat  <= sat_acc_q;
        end
      end
    end
  end

endmodule

// File: tb/tb_iir_sos_cascade.sv
// Scoreboard bench: an input observer pushes model results, an output monitor pops and compares.
module tb_iir_sos_cascade;

  localparam int unsigned DW = 32;
  localparam int unsigned CW = 32;
  localparam int unsigned IW = 64;
  localparam int unsigned SS = 20;
  localparam int unsigned NS = 4;
  localparam int          Period = 26;  // 6*NS+2 cycles from acceptance to out_valid visibility

  logic              clk, rst_n, clear, in_valid, in_ready, out_valid, out_sat;
  logic              coef_we, coef_ready;
  logic signed [31:0] in_data, out_data, coef_wdata;
  logic [1:0]        coef_sec;
  logic [2:0]        coef_idx;

  iir_sos_cascade #(
    .DATA_WIDTH     (DW),
    .COEFF_WIDTH    (CW),
    .INTERNAL_WIDTH (IW),
    .SCALE_SHIFT    (SS),
    .NUM_SECTIONS   (NS)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (clear),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_sat    (out_sat),
    .coef_we    (coef_we),
    .coef_ready (coef_ready),
    .coef_sec   (coef_sec),
    .coef_idx   (coef_idx),
    .coef_wdata (coef_wdata)
  );

  typedef struct {
    int     data;
    bit     sat;
    longint cyc;
  } exp_t;

  exp_t   q[$];
  int     n_cmp = 0;
  int     n_bad = 0;
  longint cyc = 0;

  // Reference model state (owned by the observer process).
  longint cm [NS][5];
  int     x1m [NS];
  int     x2m [NS];
  int     y1m [NS];
  int     y2m [NS];
  longint busy_until = 0;
  longint prev_cyc = 0;
  bit     prev_valid = 0;
  bit     obs_busy, exp_ir;

  int     last_d = 0;
  bit     last_s = 0;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Each section: sum of five products, round-half-up, shift, clip to 32-bit signed.
  function automatic void model_run(input int xin, output int y, output bit s);
    int     xi;
    int     yk;
    longint acc;
    longint hi;
    longint lo;
    hi = (longint'(1) <<< 31) - 1;
    lo = -(longint'(1) <<< 31);
    xi = xin;
    s  = 0;
    for (int k = 0; k < NS; k++) begin
      acc = cm[k][0] * longint'(xi) + cm[k][1] * longint'(x1m[k]) + cm[k][2] * longint'(x2m[k])
          - cm[k][3] * longint'(y1m[k]) - cm[k][4] * longint'(y2m[k]);
      acc = (acc + (longint'(1) <<< (SS - 1))) >>> SS;
      if (acc > hi) begin
        yk = int'(hi);
        s  = 1;
      end else if (acc < lo) begin
        yk = int'(lo);
        s  = 1;
      end else begin
        yk = int'(acc);
      end
      x2m[k] = x1m[k];
      x1m[k] = xi;
      y2m[k] = y1m[k];
      y1m[k] = yk;
      xi     = yk;
    end
    y = xi;
  endfunction

  // Input observer: sees what the DUT will sample at the next rising edge.
  always @(negedge clk) begin
    int  y;
    bit  s;
    #1;
    if (!rst_n) begin
      for (int k = 0; k < NS; k++) begin
        for (int t = 0; t < 5; t++) cm[k][t] = (t == 0) ? (longint'(1) <<< SS) : 0;
        x1m[k] = 0; x2m[k] = 0; y1m[k] = 0; y2m[k] = 0;
      end
      busy_until = 0;
      prev_valid = 0;
    end else begin
      obs_busy = (cyc < busy_until);
      exp_ir   = !obs_busy && !clear;
      check("in_ready", longint'(in_ready), longint'(exp_ir));
      check("coef_ready", longint'(coef_ready), longint'(!obs_busy));
      if (coef_we && !obs_busy && coef_idx <= 3'd4) cm[coef_sec][coef_idx] = longint'(coef_wdata);
      if (clear) begin
        for (int k = 0; k < NS; k++) begin
          x1m[k] = 0; x2m[k] = 0; y1m[k] = 0; y2m[k] = 0;
        end
        q.delete();
        busy_until = cyc + 1;
        prev_valid = 0;
      end else if (in_valid && exp_ir) begin
        model_run(int'(in_data), y, s);
        q.push_back('{data: y, sat: s, cyc: cyc + Period});
        if (prev_valid) check("accept_interval", cyc - prev_cyc, Period);
        prev_valid = 1;
        prev_cyc   = cyc;
        busy_until = cyc + Period;
      end
      if (!in_valid) prev_valid = 0;
    end
  end

  // Output monitor.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (out_valid) begin
        if (q.size() == 0) begin
          check("unexpected_out_valid", 1, 0);
        end else begin
          e = q.pop_front();
          check("out_data", longint'(out_data), longint'(e.data));
          check("out_sat", longint'(out_sat), longint'(e.sat));
          check("out_latency", cyc, e.cyc);
        end
        last_d = out_data;
        last_s = out_sat;
      end else begin
        check("out_data_hold", longint'(out_data), longint'(last_d));
        check("out_sat_hold", longint'(out_sat), longint'(last_s));
      end
    end
  end

  task automatic send(input int v, input bit hold);
    int n = 0;
    @(negedge clk);
    in_valid = 1;
    in_data  = v;
    #1;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!in_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_timeout: in_ready still 0 after %0d cycles", n);
    end
    @(posedge clk);
    #1;
    if (!hold) in_valid = 0;
  endtask

  task automatic write_coef(input int sec, input int idx, input int val);
    @(negedge clk);
    coef_we    = 1;
    coef_sec   = 2'(sec);
    coef_idx   = 3'(idx);
    coef_wdata = val;
    @(posedge clk);
    #1;
    coef_we = 0;
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    clear = 1;
    @(posedge clk);
    #1;
    clear = 0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() > 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (q.size() > 0) check("drain_timeout", q.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 0; clear = 0; in_valid = 0; in_data = 0;
    coef_we = 0; coef_sec = 0; coef_idx = 0; coef_wdata = 0;
    repeat (3) @(negedge clk);
    rst_n = 1;
    #1;
    check("rst_out_valid", longint'(out_valid), 0);
    check("rst_out_data", longint'(out_data), 0);
    check("rst_out_sat", longint'(out_sat), 0);
    check("rst_in_ready", longint'(in_ready), 1);
    check("rst_coef_ready", longint'(coef_ready), 1);

    // Unity passthrough from reset coefficients.
    send(12345, 0);
    send(-7, 0);
    drain();

    // Lowpass in section 0: impulse response 5, 20, ...
    write_coef(0, 0, 5509);
    write_coef(0, 1, 11019);
    write_coef(0, 2, 5509);
    write_coef(0, 3, -1998080);
    write_coef(0, 4, 971584);
    send(1000, 0); send(0, 0); send(0, 0);
    drain();

    // Clear mid-computation, then the impulse response must restart from zero history.
    pulse_clear();
    send(1000, 0);
    repeat (9) @(negedge clk);
    pulse_clear();
    send(1000, 0); send(0, 0); send(0, 0);
    drain();
    pulse_clear();

    // Saturation both ways with gain 4.
    write_coef(0, 0, 4194304);
    for (int t = 1; t < 5; t++) write_coef(0, t, 0);
    send(1 << 30, 0);
    send(-(1 << 30), 0);
    drain();

    // Write while busy is dropped; the same write in idle sticks; invalid index ignored.
    send(100, 0);
    write_coef(0, 0, 1 << 21);
    drain();
    send(100, 0);
    drain();
    write_coef(0, 0, 1 << 21);
    write_coef(0, 5, 12345678);
    send(100, 0);
    drain();

    // Continuous in_valid: back-to-back acceptance every Period cycles.
    for (int i = 0; i < 5; i++) send(int'($urandom_range(0, 20000)) - 10000, 1);
    in_valid = 0;
    drain();

    // Randomized mix of samples, coefficient writes (some busy, some bad index) and clears.
    for (int i = 0; i < 80; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 65) begin
        if ($urandom_range(0, 9) == 0) send(int'($urandom), 0);
        else send(int'($urandom_range(0, 1 << 17)) - (1 << 16), 0);
      end else if (r < 93) begin
        int idx;
        int val;
        idx = int'($urandom_range(0, 7));
        if (idx < 3) val = int'($urandom_range(0, 1 << 21)) - (1 << 20);
        else val = int'($urandom_range(0, 1 << 20)) - (1 << 19);
        write_coef(int'($urandom_range(0, NS - 1)), idx, val);
      end else begin
        repeat ($urandom_range(0, 20)) @(negedge clk);
        pulse_clear();
      end
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
